// File: rtl/exu_bjp_ctrl.sv
// exu_bjp_ctrl: redirect sequencer for resolved branches/jumps from the EXU.
// A taken jump captures its target, flushes IF/ID for FLUSH_CYCLES cycles,
// then offers a redirect to the IFU under valid/ready. EX is stalled
// throughout, and completed redirects are counted.
//
// Optional feature macro: BJP_MISALIGN_CHK_EN
//   When defined, a target with bit1 set raises a one-cycle misaligned-target
//   exception instead of a redirect. When undefined, no check is made and the
//   exception outputs are tied to 0.
//
// Ports:
//   i_clk, i_rst_n     clock, synchronous active-low reset
//   i_bjp_valid        resolved branch/jump present in EX
//   i_jump_en          branch/jump is taken
//   i_jump_addr        computed target
//   i_pc               PC of the branch/jump (not needed for the redirect itself)
//   i_kill             trap/interrupt abort, overrides everything
//   o_bjp_ready        high only in idle
//   o_stall            high whenever a redirect sequence is in progress
//   o_flush            IF/ID flush
//   o_redir_valid      redirect request to IFU; i_redir_ready accepts it
//   o_redir_pc         redirect target (bit0 cleared)
//   o_redir_cnt        completed redirects, wrapping
//   o_misalign_exc     misaligned-target pulse (optional feature)
//   o_exc_tval         faulting target (optional feature)
module exu_bjp_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned CNT_W        = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_bjp_valid,
  input  logic             i_jump_en,
  input  logic [31:0]      i_jump_addr,
  input  logic [31:0]      i_pc,
  input  logic             i_kill,
  output logic             o_bjp_ready,
  output logic             o_stall,
  output logic             o_flush,
  output logic             o_redir_valid,
  input  logic             i_redir_ready,
  output logic [31:0]      o_redir_pc,
  output logic [CNT_W-1:0] o_redir_cnt,
  output logic             o_misalign_exc,
  output logic [31:0]      o_exc_tval
);

  typedef enum logic [1:0] {StIdle, StFlush, StRedir, StExc} state_e;

  // Counter is loaded with FLUSH_CYCLES-1 so that FLUSH lasts FLUSH_CYCLES cycles.
  localparam logic [3:0] FlushInit = (FLUSH_CYCLES == 0) ? 4'd0 : 4'(FLUSH_CYCLES - 1);

  state_e           r_state, w_state_nxt;
  logic [3:0]       r_flush_cnt, w_flush_cnt_nxt;
  logic [31:0]      r_target, w_target_nxt;
  logic [CNT_W-1:0] r_redir_cnt, w_redir_cnt_nxt;
  logic             w_misalign;

`ifdef BJP_MISALIGN_CHK_EN
  logic [31:0] r_tval, w_tval_nxt;
  logic        w_unused;

  assign w_misalign = i_jump_addr[1];
  assign w_unused   = ^i_pc;
`else
  logic w_unused;

  assign w_misalign = 1'b0;
  assign w_unused   = ^{i_pc, i_jump_addr[0]};
`endif

  always_comb begin
    w_state_nxt     = r_state;
    w_flush_cnt_nxt = r_flush_cnt;
    w_target_nxt    = r_target;
    w_redir_cnt_nxt = r_redir_cnt;
`ifdef BJP_MISALIGN_CHK_EN
    w_tval_nxt      = r_tval;
`endif
    if (i_kill) begin
      // Kill wins in every state: drops accepts and pending handshakes alike.
      w_state_nxt     = StIdle;
      w_flush_cnt_nxt = 4'd0;
    end else begin
      case (r_state)
        StIdle: begin
          if (i_bjp_valid && i_jump_en) begin
            if (w_misalign) begin
              w_state_nxt = StExc;
`ifdef BJP_MISALIGN_CHK_EN
              w_tval_nxt  = i_jump_addr;
`endif
            end else begin
              w_target_nxt = {i_jump_addr[31:1], 1'b0};
              if (FLUSH_CYCLES == 0) begin
                w_state_nxt = StRedir;
              end else begin
                w_state_nxt     = StFlush;
                w_flush_cnt_nxt = FlushInit;
              end
            end
          end
        end
        StFlush: begin
          if (r_flush_cnt == 4'd0) begin
            w_state_nxt = StRedir;
          end else begin
            w_flush_cnt_nxt = r_flush_cnt - 4'd1;
          end
        end
        StRedir: begin
          if (i_redir_ready) begin
            w_state_nxt     = StIdle;
            w_redir_cnt_nxt = r_redir_cnt + 1'b1;
          end
        end
        StExc: begin
          w_state_nxt = StIdle;
        end
        default: begin
          w_state_nxt = StIdle;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state     <= StIdle;
      r_flush_cnt <= 4'd0;
      r_target    <= 32'd0;
      r_redir_cnt <= '0;
`ifdef BJP_MISALIGN_CHK_EN
      r_tval      <= 32'd0;
`endif
    end else begin
      r_state     <= w_state_nxt;
      r_flush_cnt <= w_flush_cnt_nxt;
      r_target    <= w_target_nxt;
      r_redir_cnt <= w_redir_cnt_nxt;
`ifdef BJP_MISALIGN_CHK_EN
      r_tval      <= w_tval_nxt;
`endif
    end
  end

  // All outputs decode registered state; nothing combinational from i_redir_ready.
  assign o_bjp_ready   = (r_state == StIdle);
  assign o_stall       = (r_state != StIdle);
  assign o_flush       = (r_state == StFlush);
  assign o_redir_valid = (r_state == StRedir);
  assign o_redir_pc    = r_target;
  assign o_redir_cnt   = r_redir_cnt;

`ifdef BJP_MISALIGN_CHK_EN
  assign o_misalign_exc = (r_state == StExc);
  assign o_exc_tval     = r_tval;
`else
  assign o_misalign_exc = 1'b0;
  assign o_exc_tval     = 32'd0;
`endif

endmodule

// File: tb/tb_exu_bjp_ctrl.sv
// Bench for exu_bjp_ctrl. Instance "a" uses the default parameters; instance
// "b" uses FLUSH_CYCLES=0 and a 2-bit counter to reach the wrap quickly.
module tb_exu_bjp_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, bjp_valid, jump_en, kill, redir_ready;
  logic [31:0] jump_addr, pc;
  logic        a_ready, a_stall, a_flush, a_valid, a_exc;
  logic [31:0] a_pc, a_cnt, a_tval;

  logic        b_bjp_valid, b_kill, b_ready_in;
  logic [31:0] b_addr;
  logic        b_ready, b_stall, b_flush, b_valid, b_exc;
  logic [31:0] b_pc, b_tval;
  logic [1:0]  b_cnt;

  exu_bjp_ctrl u_dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_bjp_valid(bjp_valid), .i_jump_en(jump_en),
    .i_jump_addr(jump_addr), .i_pc(pc), .i_kill(kill), .o_bjp_ready(a_ready),
    .o_stall(a_stall), .o_flush(a_flush), .o_redir_valid(a_valid),
    .i_redir_ready(redir_ready), .o_redir_pc(a_pc), .o_redir_cnt(a_cnt),
    .o_misalign_exc(a_exc), .o_exc_tval(a_tval)
  );

  exu_bjp_ctrl #(.FLUSH_CYCLES(0), .CNT_W(2)) u_dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_bjp_valid(b_bjp_valid), .i_jump_en(1'b1),
    .i_jump_addr(b_addr), .i_pc(pc), .i_kill(b_kill), .o_bjp_ready(b_ready),
    .o_stall(b_stall), .o_flush(b_flush), .o_redir_valid(b_valid),
    .i_redir_ready(b_ready_in), .o_redir_pc(b_pc), .o_redir_cnt(b_cnt),
    .o_misalign_exc(b_exc), .o_exc_tval(b_tval)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // Scoreboard of expected redirects for instance a: target and count after it.
  typedef struct packed {logic [31:0] pc; logic [31:0] cnt;} exp_t;
  exp_t q[$];

  task automatic expect_redir(input logic [31:0] p, input logic [31:0] c);
    exp_t e;
    e.pc  = p;
    e.cnt = c;
    q.push_back(e);
  endtask

  int          n_flush = 0, n_stall = 0, n_valid = 0, n_exc = 0, nb_flush = 0;
  logic        hold_vld = 1'b0;
  logic [31:0] hold_pc  = 32'd0;
  logic        cnt_pend = 1'b0;
  logic [31:0] cnt_exp  = 32'd0;

  // Monitor: samples mid-cycle, pops the scoreboard on each completed handshake.
  always @(negedge clk) begin
    if (rst_n) begin
      exp_t e;
      if (cnt_pend) begin
        chk("redir_cnt_after_handshake", a_cnt, cnt_exp);
        cnt_pend = 1'b0;
      end
      if (a_flush) n_flush++;
      if (a_stall) n_stall++;
      if (a_valid) n_valid++;
      if (a_exc) begin
        n_exc++;
        chk("exc_tval", a_tval, 32'h0000_3002);
      end
      if (b_flush) nb_flush++;
      if (a_valid && hold_vld) chk("redir_pc_stable", a_pc, hold_pc);
      hold_vld = a_valid && !redir_ready && !kill;
      hold_pc  = a_pc;
      if (a_valid && redir_ready && !kill) begin
        if (q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_redirect: got pc 0x%08h expected none", a_pc);
        end else begin
          e = q.pop_front();
          chk("redir_pc", a_pc, e.pc);
          cnt_pend = 1'b1;
          cnt_exp  = e.cnt;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int f0, s0, v0, e0;

  initial begin
    rst_n = 1'b0; bjp_valid = 1'b0; jump_en = 1'b0; jump_addr = 32'd0; pc = 32'h100;
    kill = 1'b0; redir_ready = 1'b0;
    b_bjp_valid = 1'b0; b_kill = 1'b0; b_ready_in = 1'b0; b_addr = 32'd0;
    repeat (3) step();
    chk("reset_bjp_ready", {31'd0, a_ready}, 32'd1);
    chk("reset_stall", {31'd0, a_stall}, 32'd0);
    chk("reset_flush", {31'd0, a_flush}, 32'd0);
    chk("reset_redir_valid", {31'd0, a_valid}, 32'd0);
    chk("reset_redir_pc", a_pc, 32'd0);
    chk("reset_redir_cnt", a_cnt, 32'd0);
    chk("reset_misalign", {31'd0, a_exc}, 32'd0);
    chk("reset_tval", a_tval, 32'd0);
    rst_n = 1'b1;
    step();

    // Taken jump, ready tied high; EX keeps valid up with junk while stalled.
    redir_ready = 1'b1;
    f0 = n_flush; s0 = n_stall; v0 = n_valid;
    bjp_valid = 1'b1; jump_en = 1'b1; jump_addr = 32'h0000_1004;
    expect_redir(32'h0000_1004, 32'd1);
    step();
    jump_addr = 32'hDEAD_BEEC;
    step();
    step();
    bjp_valid = 1'b0;
    repeat (3) step();
    chk("t1_flush_cycles", n_flush - f0, 32'd2);
    chk("t1_valid_cycles", n_valid - v0, 32'd1);
    chk("t1_stall_cycles", n_stall - s0, 32'd3);
    chk("t1_cnt", a_cnt, 32'd1);

    // Not-taken branch.
    f0 = n_flush; s0 = n_stall; v0 = n_valid;
    bjp_valid = 1'b1; jump_en = 1'b0; jump_addr = 32'h0000_7770;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("nt_bjp_ready", {31'd0, a_ready}, 32'd1);
    end
    bjp_valid = 1'b0;
    step();
    chk("nt_flush", n_flush - f0, 32'd0);
    chk("nt_valid", n_valid - v0, 32'd0);
    chk("nt_stall", n_stall - s0, 32'd0);
    chk("nt_cnt", a_cnt, 32'd1);

    // JALR with odd target and 5 cycles of back-pressure in REDIR.
    redir_ready = 1'b0;
    s0 = n_stall; v0 = n_valid;
    bjp_valid = 1'b1; jump_en = 1'b1; jump_addr = 32'h0000_2001;
    expect_redir(32'h0000_2000, 32'd2);
    step();
    bjp_valid = 1'b0;
    step();
    step();
    repeat (4) step();
    step();
    redir_ready = 1'b1;
    step();
    step();
    chk("bp_valid_cycles", n_valid - v0, 32'd6);
    chk("bp_stall_cycles", n_stall - s0, 32'd8);
    chk("bp_cnt", a_cnt, 32'd2);

    // Kill in the second FLUSH cycle, then a fresh jump right away.
    f0 = n_flush;
    bjp_valid = 1'b1; jump_addr = 32'h0000_4000;
    step();
    bjp_valid = 1'b0;
    step();
    kill = 1'b1;
    step();
    kill = 1'b0;
    chk("kill_bjp_ready", {31'd0, a_ready}, 32'd1);
    chk("kill_flush", {31'd0, a_flush}, 32'd0);
    chk("kill_valid", {31'd0, a_valid}, 32'd0);
    chk("kill_cnt", a_cnt, 32'd2);
    bjp_valid = 1'b1; jump_addr = 32'h0000_5008;
    expect_redir(32'h0000_5008, 32'd3);
    step();
    bjp_valid = 1'b0;
    chk("accept_after_kill", {31'd0, a_flush}, 32'd1);
    repeat (4) step();
    chk("kill_seq_flush_cycles", n_flush - f0, 32'd4);
    chk("kill_seq_cnt", a_cnt, 32'd3);

    // Kill coinciding with an accept.
    kill = 1'b1; bjp_valid = 1'b1; jump_addr = 32'h0000_6000;
    step();
    kill = 1'b0; bjp_valid = 1'b0;
    chk("kill_accept_stall", {31'd0, a_stall}, 32'd0);
    step();

    // Kill coinciding with the REDIR handshake.
    redir_ready = 1'b0;
    bjp_valid = 1'b1; jump_addr = 32'h0000_6100;
    step();
    bjp_valid = 1'b0;
    step();
    step();
    chk("redir_before_kill", {31'd0, a_valid}, 32'd1);
    redir_ready = 1'b1; kill = 1'b1;
    step();
    kill = 1'b0;
    chk("kill_handshake_stall", {31'd0, a_stall}, 32'd0);
    step();
    chk("kill_handshake_cnt", a_cnt, 32'd3);

    // Target with bit1 set.
    e0 = n_exc; v0 = n_valid;
    bjp_valid = 1'b1; jump_addr = 32'h0000_3002;
`ifdef BJP_MISALIGN_CHK_EN
    step();
    bjp_valid = 1'b0;
    chk("misalign_pulse", {31'd0, a_exc}, 32'd1);
    chk("misalign_stall", {31'd0, a_stall}, 32'd1);
    step();
    chk("misalign_pulse_end", {31'd0, a_exc}, 32'd0);
    step();
    chk("misalign_exc_cycles", n_exc - e0, 32'd1);
    chk("misalign_no_redir", n_valid - v0, 32'd0);
    chk("misalign_cnt", a_cnt, 32'd3);
`else
    expect_redir(32'h0000_3002, 32'd4);
    step();
    bjp_valid = 1'b0;
    repeat (5) step();
    chk("nochk_exc_cycles", n_exc - e0, 32'd0);
    chk("nochk_cnt", a_cnt, 32'd4);
`endif

    // Zero-flush instance: redirect one cycle after accept, 2-bit count wraps.
    b_ready_in = 1'b1;
    for (int i = 0; i < 4; i++) begin
      b_bjp_valid = 1'b1;
      b_addr = 32'h0000_8001 + 32'(i * 8);
      step();
      b_bjp_valid = 1'b0;
      chk("b_redir_latency", {31'd0, b_valid}, 32'd1);
      chk("b_redir_pc", b_pc, 32'h0000_8000 + 32'(i * 8));
      step();
      chk("b_cnt", {30'd0, b_cnt}, 32'((i + 1) % 4));
    end
    chk("b_never_flush", nb_flush, 32'd0);

    repeat (2) step();
    n_checks++;
    if (q.size() == 0) n_pass++;
    else $display("FAIL scoreboard_drain: got %0d pending redirects expected 0", q.size());
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/exu_bjp_ctrl.md
Name: exu_bjp_ctrl

Overview:
- Sequences pipeline redirection for resolved branches and jumps coming out of the EXU branch/jump unit.
- On a taken jump, the block captures the target, flushes IF/ID for a programmable number of cycles, then presents a redirect to the IFU under a valid/ready handshake.
- Stalls EX while a redirect is in progress and keeps a running count of completed redirects.

Parameters:
- FLUSH_CYCLES, 2, number of cycles o_flush is held after capture; legal 0..15.
- CNT_W, 32, width of the redirect counter o_redir_cnt.

Ports:
- i_clk  in  1  core clock.
- i_rst_n  in  1  reset, synchronous, active-low.
- i_bjp_valid  in  1  EX holds a resolved branch/jump this cycle.
- i_jump_en  in  1  resolved jump/branch is taken.
- i_jump_addr  in  32  computed target address.
- i_pc  in  32  PC of the branch/jump instruction.
- i_kill  in  1  trap/interrupt abort; cancels any redirect in progress.
- o_bjp_ready  out  1  controller can accept a resolution (high only in IDLE).
- o_stall  out  1  hold EX/upstream; high whenever state != IDLE.
- o_flush  out  1  flush IF/ID stages.
- o_redir_valid  out  1  redirect request to IFU.
- i_redir_ready  in  1  IFU accepts redirect.
- o_redir_pc  out  32  redirect target, bit0 forced to 0.
- o_redir_cnt  out  CNT_W  completed redirects, wraps modulo 2^CNT_W.
- o_misalign_exc  out  1  target-misaligned exception pulse (optional feature only; tied 0 otherwise).
- o_exc_tval  out  32  faulting target address (optional feature only; tied 0 otherwise).

Behaviour:
- Clock and reset: one clock, i_clk. Reset i_rst_n is synchronous and active-low.
- Reset values: state IDLE; all outputs 0 except o_bjp_ready = 1; flush counter 0; target register 0.
- States: IDLE, FLUSH, REDIR.
- Accept: in IDLE when i_bjp_valid & i_jump_en, latch {i_jump_addr[31:1], 1'b0} into the target register at that edge.
  - FLUSH_CYCLES > 0: go to FLUSH and load the counter with FLUSH_CYCLES-1.
  - FLUSH_CYCLES == 0: go straight to REDIR.
- Not taken: i_bjp_valid & ~i_jump_en in IDLE causes no state change and no output activity.
- i_bjp_valid outside IDLE is ignored; upstream must hold it while o_stall is high.
- FLUSH:
  - o_flush = 1 every cycle in this state; the counter decrements.
  - When the counter is 0, go to REDIR at the next edge.
  - o_flush is therefore high for exactly FLUSH_CYCLES cycles, starting the cycle after acceptance.
- REDIR:
  - o_redir_valid = 1 and o_redir_pc = target register, both stable until the handshake.
  - On i_redir_ready: go to IDLE and increment o_redir_cnt.
  - Back-pressure of any length is tolerated.
- Latency: accept at edge N; with FLUSH_CYCLES = F, o_redir_valid first rises in cycle N+1+F.
- i_kill:
  - Highest priority in every state. The next state is IDLE, the counter is cleared, and o_redir_cnt is not incremented.
  - A kill coinciding with an IDLE accept discards the accept.
  - A kill coinciding with the REDIR handshake discards the handshake: no count, and the IFU must treat kill as overriding.
- Outputs are registered/decoded from state only. No combinational path from i_redir_ready to o_redir_valid.
- Counter wrap: at all-ones, the next completed redirect gives 0.

Optional Feature:
- Macro: BJP_MISALIGN_CHK_EN.
- Defined:
  - On accept, if i_jump_addr[1] == 1, enter no flush/redirect.
  - Instead, pulse o_misalign_exc for exactly one cycle (the cycle after accept) with o_exc_tval = i_jump_addr, then return to IDLE.
  - o_stall is high during that cycle; o_redir_cnt is unchanged.
  - i_kill in the same cycle as the accept suppresses the pulse.
- Not defined:
  - No address check. o_misalign_exc and o_exc_tval are tied to 0.
  - A misaligned target is redirected normally, with bit0 cleared.

Test Plan:
- Reset, then taken jump to 0x0000_1004 with FLUSH_CYCLES=2, i_redir_ready tied 1 -> o_flush high 2 cycles, o_redir_valid high 1 cycle with o_redir_pc=0x0000_1004, o_redir_cnt=1, o_stall high 3 cycles.
- Not-taken branch (i_bjp_valid=1, i_jump_en=0) -> no o_flush, no o_redir_valid, o_bjp_ready stays 1, counter unchanged.
- JALR target 0x0000_2001, i_redir_ready held 0 for 5 cycles in REDIR -> o_redir_pc=0x0000_2000 held stable for 6 cycles, single count increment on handshake.
- i_kill asserted in second FLUSH cycle -> IDLE next cycle, o_flush/o_redir_valid drop, o_redir_cnt unchanged, new jump accepted the following cycle.
- FLUSH_CYCLES=0 build: taken jump at edge N -> o_redir_valid at cycle N+1, o_flush never asserted; counter preloaded by 2^32-1 redirects wraps to 0.
- BJP_MISALIGN_CHK_EN build: target 0x0000_3002 -> o_misalign_exc one-cycle pulse, o_exc_tval=0x0000_3002, no o_redir_valid, o_redir_cnt unchanged.
